// File: rtl/gcd_fraction_reducer_if.sv
// Handshake and result bundle between the GCD unit, the fraction reducer
// and the report stage.
interface gcd_fraction_reducer_if #(
  parameter int WIDTH = 8
);
  logic                 Complete;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     gcd;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     num;
  logic [WIDTH-1:0]     den;
  logic [2*WIDTH-1:0]   lcm;
  logic                 err;

  modport master (
    output Complete, a, b, gcd,
    input  busy, done, num, den, lcm, err
  );

  modport slave (
    input  Complete, a, b, gcd,
    output busy, done, num, den, lcm, err
  );
endinterface

// File: rtl/gcd_fraction_reducer.sv
// Reduces a/b by a supplied gcd and forms lcm = (a/gcd)*b using serial
// restoring division and shift-add multiplication.
module gcd_fraction_reducer #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gcd_fraction_reducer_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIV_A = 3'd1,
    DIV_B = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [WIDTH-1:0]     b_reg, b_next;
  logic [WIDTH-1:0]     g_reg, g_next;
  logic [WIDTH-1:0]     work_reg, work_next;
  logic [WIDTH:0]       rem_reg, rem_next;
  logic [WIDTH-1:0]     qa_reg, qa_next;
  logic [WIDTH-1:0]     qb_reg, qb_next;
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic                 err_acc_reg, err_acc_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [WIDTH-1:0]     num_reg, num_next;
  logic [WIDTH-1:0]     den_reg, den_next;
  logic [2*WIDTH-1:0]   lcm_reg, lcm_next;
  logic                 err_reg, err_next;

  // One restoring-division step, shared by both division phases: the dividend
  // shifts out of work_reg MSB-first while quotient bits shift in at the LSB.
  logic [WIDTH:0]       trial;
  logic                 ge;
  logic [WIDTH:0]       rem_step;
  logic [WIDTH-1:0]     quo_step;
  logic                 cnt_last;

  assign trial    = {rem_reg[WIDTH-1:0], work_reg[WIDTH-1]};
  assign ge       = (trial >= {1'b0, g_reg});
  assign rem_step = ge ? (trial - {1'b0, g_reg}) : trial;
  assign quo_step = {work_reg[WIDTH-2:0], ge};
  assign cnt_last = (cnt_reg == LAST);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    b_next       = b_reg;
    g_next       = g_reg;
    work_next    = work_reg;
    rem_next     = rem_reg;
    qa_next      = qa_reg;
    qb_next      = qb_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    err_acc_next = err_acc_reg;
    busy_next    = busy_reg;
    done_next    = done_reg;
    num_next     = num_reg;
    den_next     = den_reg;
    lcm_next     = lcm_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE: begin
        if (bus.Complete) begin
          b_next       = bus.b;
          g_next       = bus.gcd;
          work_next    = bus.a;
          rem_next     = '0;
          cnt_next     = '0;
          err_acc_next = 1'b0;
          busy_next    = 1'b1;
          if (bus.gcd == '0) begin
            // Undefined reduction: report the raw operands and flag it.
            qa_next      = bus.a;
            qb_next      = bus.b;
            acc_next     = '0;
            err_acc_next = 1'b1;
            state_next   = DONE;
          end else begin
            state_next   = DIV_A;
          end
        end
      end

      DIV_A: begin
        rem_next  = rem_step;
        work_next = quo_step;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_last) begin
          qa_next      = quo_step;
          err_acc_next = err_acc_reg | (rem_step != '0);
          work_next    = b_reg;
          rem_next     = '0;
          cnt_next     = '0;
          state_next   = DIV_B;
        end
      end

      DIV_B: begin
        rem_next  = rem_step;
        work_next = quo_step;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_last) begin
          qb_next      = quo_step;
          err_acc_next = err_acc_reg | (rem_step != '0);
          mcand_next   = {{WIDTH{1'b0}}, qa_reg};
          mplier_next  = b_reg;
          acc_next     = '0;
          cnt_next     = '0;
          state_next   = MUL;
        end
      end

      MUL: begin
        if (mplier_reg[0]) begin
          acc_next = acc_reg + mcand_reg;
        end
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_last) begin
          cnt_next   = '0;
          state_next = DONE;
        end
      end

      DONE: begin
        // First cycle publishes results; the second (done high) retires to IDLE,
        // so a Complete coinciding with done is never captured.
        if (!done_reg) begin
          num_next  = qa_reg;
          den_next  = qb_reg;
          lcm_next  = acc_reg;
          err_next  = err_acc_reg;
          done_next = 1'b1;
        end else begin
          done_next  = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      b_reg       <= '0;
      g_reg       <= '0;
      work_reg    <= '0;
      rem_reg     <= '0;
      qa_reg      <= '0;
      qb_reg      <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      err_acc_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      num_reg     <= '0;
      den_reg     <= '0;
      lcm_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      b_reg       <= b_next;
      g_reg       <= g_next;
      work_reg    <= work_next;
      rem_reg     <= rem_next;
      qa_reg      <= qa_next;
      qb_reg      <= qb_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      err_acc_reg <= err_acc_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      num_reg     <= num_next;
      den_reg     <= den_next;
      lcm_reg     <= lcm_next;
      err_reg     <= err_next;
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.num  = num_reg;
  assign bus.den  = den_reg;
  assign bus.lcm  = lcm_reg;
  assign bus.err  = err_reg;

endmodule

// File: tb/tb_gcd_fraction_reducer.sv
// Scoreboard bench for gcd_fraction_reducer: directed cases from the test
// plan followed by randomized operand pairs against an arithmetic model.
module tb_gcd_fraction_reducer;

  localparam int W = 8;
  localparam int NOMINAL_LAT = 3 * W + 1;

  typedef struct {
    logic [W-1:0]   num;
    logic [W-1:0]   den;
    logic [2*W-1:0] lcm;
    logic           err;
    int             k;
    int             lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  gcd_fraction_reducer_if #(.WIDTH(W)) bus ();

  gcd_fraction_reducer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic logic [W-1:0] euclid(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g);
    exp_t e;
    if (g == 0) begin
      e.num = a;
      e.den = b;
      e.lcm = '0;
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      e.num = a / g;
      e.den = b / g;
      e.lcm = (2*W)'(int'(a / g) * int'(b));
      e.err = ((a % g) != 0) || ((b % g) != 0);
      e.lat = NOMINAL_LAT;
    end
    e.k = 0;
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: num=%0d den=%0d lcm=%0d err=%0d with no pending request",
                 bus.num, bus.den, bus.lcm, bus.err);
      end else begin
        e = sb.pop_front();
        chk("num", 64'(bus.num), 64'(e.num));
        chk("den", 64'(bus.den), 64'(e.den));
        chk("lcm", 64'(bus.lcm), 64'(e.lcm));
        chk("err", 64'(bus.err), 64'(e.err));
        chk("latency", 64'(cyc - e.k), 64'(e.lat));
        chk("busy_with_done", 64'(bus.busy), 64'd1);
        $display("txn done at cycle %0d: num=%0d den=%0d lcm=%0d err=%0d", cyc, bus.num, bus.den, bus.lcm, bus.err);
      end
    end
  end

  task automatic scramble_inputs();
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.gcd = W'($urandom);
  endtask

  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g, input bit expect_it);
    exp_t e;
    @(negedge clk);
    bus.Complete = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.gcd      = g;
    if (expect_it) begin
      e   = model(a, b, g);
      e.k = cyc + 1;
      sb.push_back(e);
      $display("txn issue  a=%0d b=%0d gcd=%0d at edge %0d", a, b, g, e.k);
    end
    @(negedge clk);
    bus.Complete = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_done(input int limit, input bit poke);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (poke) begin
      bus.Complete = 1'b1;
      scramble_inputs();
    end
    @(negedge clk);
    bus.Complete = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g);
    pulse(a, b, g, 1'b1);
    wait_done(NOMINAL_LAT + 10, 1'b0);
  endtask

  initial begin
    bit all_busy;
    bit saw_done;
    logic [W-1:0] ra, rb, rg;

    n_checks     = 0;
    n_pass       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    bus.Complete = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.gcd      = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_num",  64'(bus.num),  64'd0);
    chk("reset_den",  64'(bus.den),  64'd0);
    chk("reset_lcm",  64'(bus.lcm),  64'd0);
    chk("reset_err",  64'(bus.err),  64'd0);
    rst_n = 1'b1;

    run(8'd78, 8'd24, 8'd6);
    run(8'd22, 8'd77, 8'd11);
    run(8'd255, 8'd25, 8'd5);
    run(8'd236, 8'd136, 8'd4);
    run(8'd100, 8'd120, 8'd20);
    run(8'd0, 8'd0, 8'd0);
    run(8'd9, 8'd0, 8'd9);
    run(8'd10, 8'd15, 8'd4);

    // A Complete landing in the done cycle must not start anything.
    pulse(8'd30, 8'd45, 8'd15, 1'b1);
    wait_done(NOMINAL_LAT + 10, 1'b1);
    saw_done = 1'b0;
    repeat (NOMINAL_LAT + 5) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    chk("done_cycle_complete_ignored", 64'(saw_done), 64'd0);

    // Complete while busy is ignored and busy never drops early.
    pulse(8'd78, 8'd24, 8'd6, 1'b1);
    repeat (3) @(negedge clk);
    pulse(8'd22, 8'd77, 8'd11, 1'b0);
    all_busy = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < NOMINAL_LAT + 10 && !saw_done; i++) begin
      if (!bus.busy) all_busy = 1'b0;
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    chk("busy_held", 64'(all_busy), 64'd1);
    chk("done_after_ignore", 64'(saw_done), 64'd1);
    saw_done = 1'b0;
    repeat (NOMINAL_LAT + 5) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    chk("single_done", 64'(saw_done), 64'd0);

    // Reset mid-operation aborts and clears everything.
    pulse(8'd255, 8'd25, 8'd5, 1'b1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_num",  64'(bus.num),  64'd0);
    chk("abort_den",  64'(bus.den),  64'd0);
    chk("abort_lcm",  64'(bus.lcm),  64'd0);
    chk("abort_err",  64'(bus.err),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (NOMINAL_LAT + 5) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    chk("no_done_after_abort", 64'(saw_done), 64'd0);
    run(8'd100, 8'd120, 8'd20);

    // Randomized pairs; some carry a deliberately wrong or zero gcd.
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(0, 255));
      if (n % 5 == 4) rg = W'($urandom_range(0, 12));
      else rg = euclid(ra, rb);
      run(ra, rb, rg);
    end

    repeat (NOMINAL_LAT + 5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
